// File: rtl/mul_add_pkg.sv
// Shared definitions for the mul-add block accumulator: default widths and FSM state encoding.
package mul_add_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder; one spare bit catches the carry, which clamps the sum and raises ovf.
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] wide;

    assign wide = {1'b0, a} + {1'b0, b};
    assign ovf  = wide[W];
    assign sum  = ovf ? {W{1'b1}} : wide[W-1:0];

endmodule

// File: rtl/mul_add_accum.sv
// Sums blocks of BLOCK_LEN unsigned product samples (or fewer on flush) and holds each
// saturated result on a valid/ready output until it is taken.
//
// state | meaning
// IDLE  | no partial block; next accepted sample starts a new block
// ACC   | partial block in progress, cnt >= 1
// HOLD  | result registered on out_*, input stalled until out_ready
module mul_add_accum #(
    parameter int BLOCK_LEN = 8,
    parameter int ACC_W     = mul_add_pkg::ACC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [mul_add_pkg::DATA_W-1:0] in_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_sum,
    output logic [7:0]                    out_count,
    output logic                          out_sat
);

    import mul_add_pkg::*;

    localparam logic [7:0] LEN = 8'(BLOCK_LEN);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             sat;

    logic             xfer;
    logic             done;
    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_nxt;
    logic [7:0]       cnt_nxt;
    logic             sat_nxt;

    assign in_ready = (state != HOLD);
    assign xfer     = in_valid && (state != HOLD);
    assign data_ext = ACC_W'(in_data);

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (data_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next block contents as they will stand after this edge; the result registers
    // load from these so a flushing or final sample is already included.
    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (xfer) begin
            if (state == IDLE) begin
                acc_nxt = data_ext;
                cnt_nxt = 8'd1;
                sat_nxt = 1'b0;
            end else begin
                acc_nxt = add_sum;
                cnt_nxt = cnt + 8'd1;
                sat_nxt = sat | add_ovf;
            end
        end
    end

    assign done = (xfer && (cnt_nxt == LEN)) || ((state == ACC) && flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    sat <= sat_nxt;
                    if (done) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_sum   <= acc_nxt;
                        out_count <= cnt_nxt;
                        out_sat   <= sat_nxt;
                    end else if (xfer) begin
                        state <= ACC;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_count <= '0;
                        out_sat   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_add_accum.sv
// Bench for mul_add_accum: directed scenarios on three parameterisations plus a randomized
// run checked against a block-level reference model.
module tb_mul_add_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [7:0]  in_data;

    logic        a_in_ready, a_out_valid, a_out_sat;
    logic [15:0] a_out_sum;
    logic [7:0]  a_out_count;

    logic        b_in_ready, b_out_valid, b_out_sat;
    logic [7:0]  b_out_sum;
    logic [7:0]  b_out_count;

    logic        c_in_ready, c_out_valid, c_out_sat;
    logic [15:0] c_out_sum;
    logic [7:0]  c_out_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mul_add_accum #(.BLOCK_LEN(8), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
        .out_count(a_out_count), .out_sat(a_out_sat)
    );

    mul_add_accum #(.BLOCK_LEN(2), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
        .out_count(b_out_count), .out_sat(b_out_sat)
    );

    mul_add_accum #(.BLOCK_LEN(1), .ACC_W(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready), .out_sum(c_out_sum),
        .out_count(c_out_count), .out_sat(c_out_sat)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        total++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 16'd0 ||
            a_out_count !== 8'd0 || a_out_sat !== 1'b0)
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b sum=%0d cnt=%0d sat=%0b want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_sat);
        else passed++;
        in_valid = 1'b1;
        in_data  = 8'd9;
        tick();
        total++;
        if (c_out_valid !== 1'b0 || c_out_sum !== 16'd0)
            $display("FAIL reset_holds_idle: got vld=%0b sum=%0d want 0 0", c_out_valid, c_out_sum);
        else passed++;
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        total++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0)
            $display("FAIL post_reset_idle: got rdy=%0b vld_a=%0b vld_b=%0b want 1 0 0",
                     a_in_ready, a_out_valid, b_out_valid);
        else passed++;
    endtask

    task automatic test_sum_1_to_8();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            if (i < 8) begin
                total++;
                if (a_out_valid !== 1'b0)
                    $display("FAIL early_valid: got 1 want 0 after sample %0d", i);
                else passed++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 16'd36 || a_out_count !== 8'd8 ||
            a_out_sat !== 1'b0 || a_in_ready !== 1'b0)
            $display("FAIL sum_1_to_8: got vld=%0b sum=%0d cnt=%0d sat=%0b rdy=%0b want 1 36 8 0 0",
                     a_out_valid, a_out_sum, a_out_count, a_out_sat, a_in_ready);
        else passed++;
        handshake();
        total++;
        if (a_out_valid !== 1'b0 || a_out_sum !== 16'd0 || a_out_count !== 8'd0 || a_in_ready !== 1'b1)
            $display("FAIL after_accept: got vld=%0b sum=%0d cnt=%0d rdy=%0b want 0 0 0 1",
                     a_out_valid, a_out_sum, a_out_count, a_in_ready);
        else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'd200;
        tick();
        in_data  = 8'd100;
        tick();
        in_valid = 1'b0;
        total++;
        if (b_out_valid !== 1'b1 || b_out_sum !== 8'd255 || b_out_sat !== 1'b1 || b_out_count !== 8'd2)
            $display("FAIL saturate: got vld=%0b sum=%0d sat=%0b cnt=%0d want 1 255 1 2",
                     b_out_valid, b_out_sum, b_out_sat, b_out_count);
        else passed++;
        handshake();
        in_valid = 1'b1;
        in_data  = 8'd200;
        tick();
        in_data  = 8'd55;
        tick();
        in_valid = 1'b0;
        total++;
        if (b_out_valid !== 1'b1 || b_out_sum !== 8'd255 || b_out_sat !== 1'b0)
            $display("FAIL exact_max_no_sat: got vld=%0b sum=%0d sat=%0b want 1 255 0",
                     b_out_valid, b_out_sum, b_out_sat);
        else passed++;
        handshake();
    endtask

    task automatic test_flush();
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (a_out_valid !== 1'b0)
            $display("FAIL flush_in_idle: got vld=%0b want 0", a_out_valid);
        else passed++;
        in_valid = 1'b1;
        in_data  = 8'd5;
        tick();
        in_data  = 8'd6;
        tick();
        in_data  = 8'd7;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 16'd18 || a_out_count !== 8'd3)
            $display("FAIL flush_with_sample: got vld=%0b sum=%0d cnt=%0d want 1 18 3",
                     a_out_valid, a_out_sum, a_out_count);
        else passed++;
        handshake();
        in_valid = 1'b1;
        in_data  = 8'd10;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 16'd10 || a_out_count !== 8'd1)
            $display("FAIL flush_alone: got vld=%0b sum=%0d cnt=%0d want 1 10 1",
                     a_out_valid, a_out_sum, a_out_count);
        else passed++;
        handshake();
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_data = 8'd99;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_sum !== 16'd36 || a_out_count !== 8'd8)
                $display("FAIL hold_stable: cycle %0d got rdy=%0b vld=%0b sum=%0d cnt=%0d want 0 1 36 8",
                         k, a_in_ready, a_out_valid, a_out_sum, a_out_count);
            else passed++;
            tick();
        end
        in_data   = 8'd50;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_data   = 8'd4;
        tick();
        in_valid  = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 16'd4 || a_out_count !== 8'd1)
            $display("FAIL accept_after_handshake: got vld=%0b sum=%0d cnt=%0d want 1 4 1",
                     a_out_valid, a_out_sum, a_out_count);
        else passed++;
        handshake();
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd7;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (a_out_valid !== 1'b0)
                $display("FAIL no_result_after_reset: got vld=%0b want 0", a_out_valid);
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd2;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 16'd16 || a_out_count !== 8'd8)
            $display("FAIL block_after_reset: got vld=%0b sum=%0d cnt=%0d want 1 16 8",
                     a_out_valid, a_out_sum, a_out_count);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_out_sum !== 16'd0 || a_in_ready !== 1'b1)
            $display("FAIL async_reset_in_hold: got vld=%0b sum=%0d rdy=%0b want 0 0 1",
                     a_out_valid, a_out_sum, a_in_ready);
        else passed++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_block_len_1();
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'd9;
        tick();
        in_valid = 1'b0;
        total++;
        if (c_out_valid !== 1'b1 || c_out_sum !== 16'd9 || c_out_count !== 8'd1 || c_out_sat !== 1'b0)
            $display("FAIL block_len_1: got vld=%0b sum=%0d cnt=%0d sat=%0b want 1 9 1 0",
                     c_out_valid, c_out_sum, c_out_count, c_out_sat);
        else passed++;
        handshake();
    endtask

    // Reference: a block is the list of accepted samples; its result is the clamped total.
    task automatic test_random();
        int unsigned blk[$];
        bit          hold = 1'b0;
        bit          was_acc;
        int unsigned r_sum = 0;
        int unsigned r_cnt = 0;
        bit          r_sat = 1'b0;
        int unsigned total_sum;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            total++;
            if (a_out_valid !== hold || a_in_ready !== !hold)
                $display("FAIL rand_handshake: cycle %0d got vld=%0b rdy=%0b want %0b %0b",
                         cyc, a_out_valid, a_in_ready, hold, !hold);
            else passed++;
            total++;
            if (hold && (a_out_sum !== r_sum[15:0] || a_out_count !== r_cnt[7:0] || a_out_sat !== r_sat))
                $display("FAIL rand_result: cycle %0d got sum=%0d cnt=%0d sat=%0b want %0d %0d %0b",
                         cyc, a_out_sum, a_out_count, a_out_sat, r_sum, r_cnt, r_sat);
            else if (!hold && (a_out_sum !== 16'd0 || a_out_count !== 8'd0 || a_out_sat !== 1'b0))
                $display("FAIL rand_idle_zero: cycle %0d got sum=%0d cnt=%0d sat=%0b want 0 0 0",
                         cyc, a_out_sum, a_out_count, a_out_sat);
            else passed++;

            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            flush     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);

            if (hold) begin
                if (out_ready) hold = 1'b0;
            end else begin
                was_acc = (blk.size() > 0);
                if (in_valid) blk.push_back(int'(in_data));
                if (blk.size() == 8 || (flush && was_acc)) begin
                    total_sum = 0;
                    foreach (blk[j]) total_sum += blk[j];
                    r_sat = (total_sum > 65535);
                    r_sum = r_sat ? 65535 : total_sum;
                    r_cnt = blk.size();
                    blk.delete();
                    hold = 1'b1;
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_sum_1_to_8();
        test_saturate();
        test_flush();
        test_back_pressure();
        test_reset_mid_block();
        test_block_len_1();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_add_accum.md
MUL_ADD_ACCUM -- requirements
Module: mul_add_accum

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 8: samples per accumulation block, legal range 1..255.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator and result width, minimum 8.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1: upstream 8-bit mul-add product valid.
REQ-006 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  8: unsigned product sample from the mul-add stage.
REQ-008 SHALL have port flush  input  1: end the current block early.
REQ-009 SHALL have port out_valid  output  1: block result available.
REQ-010 SHALL have port out_ready  input  1: downstream accepts the result.
REQ-011 SHALL have port out_sum  output  ACC_W: unsigned block sum.
REQ-012 SHALL have port out_count  output  8: number of samples summed into out_sum.
REQ-013 SHALL have port out_sat  output  1: sum saturated during this block.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and HOLD.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in HOLD.
REQ-016 SHALL treat a transfer as in_valid&&in_ready on a rising clk edge; in_data is ignored otherwise.
REQ-017 On a transfer in IDLE, SHALL set acc=in_data, cnt=1, sat=0, then go to ACC, or to HOLD if BLOCK_LEN==1.
REQ-018 On a transfer in ACC, SHALL set acc=acc+in_data with saturation at 2^ACC_W-1, set sat sticky on overflow, and increment cnt.
REQ-019 SHALL go ACC->HOLD on the edge where cnt reaches BLOCK_LEN.
REQ-020 When flush=1 in ACC, SHALL go to HOLD on that edge; a same-cycle transfer is included in the result first.
REQ-021 SHALL ignore flush in IDLE and HOLD.
REQ-022 In HOLD, SHALL drive out_valid=1 with out_sum=acc, out_count=cnt, out_sat=sat, registered and stable until accepted.
REQ-023 SHALL assert out_valid the cycle after the final (or flushing) transfer, giving latency 1 clk.
REQ-024 SHALL, on out_valid&&out_ready, go to IDLE and deassert out_valid on the next cycle; outputs SHALL then be 0.
REQ-025 SHALL produce out_valid with no combinational path from in_* or out_ready.
REQ-026 SHALL zero-extend in_data to ACC_W before the add; the saturating add SHALL use ACC_W+1 bits internally.
REQ-027 SHALL never drop a sample: each accepted sample appears in exactly one result.

Reset
REQ-028 Asserting rst at any time, including mid-block or in HOLD, SHALL immediately force state=IDLE, acc=0, cnt=0 and sat=0, discarding any partial block.
REQ-029 During and after reset SHALL hold in_ready=1 in IDLE and out_valid=0, out_sum=0, out_count=0, out_sat=0.

Structure
REQ-030 Package mul_add_pkg SHALL hold the FSM state enum and default widths DATA_W=8 and ACC_W=16.
REQ-031 The saturating adder SHALL be one sub-module, sat_add (ACC_W-parameterised, combinational, with an overflow flag out).

Verification
REQ-032 BLOCK_LEN=8, eight back-to-back samples 1..8 -> out_valid one cycle after the 8th, out_sum=36, out_count=8, out_sat=0.
REQ-033 ACC_W=8, samples 200,100 with BLOCK_LEN=2 -> out_sum=255, out_sat=1.
REQ-034 Three samples 5,6,7, with flush asserted alongside the 7 -> out_sum=18, out_count=3.
REQ-035 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_* stable; first sample is accepted only after the result handshake.
REQ-036 rst pulse after 4 of 8 samples -> no out_valid; the next 8 samples of value 2 give out_sum=16.
REQ-037 BLOCK_LEN=1, sample 9 -> out_valid the next cycle with out_sum=9, out_count=1.
